// File: rtl/mrt_pkg.sv
// Shared definitions for the modular-reduction datapath (multiplier and carry normalizer).
// Chunk geometry of the redundant CPA product lives here so both sides agree on it.
// Also holds the normalizer state encoding.
package mrt_pkg;

  // Polynomial geometry feeding the multiplier
  localparam int NumCoeffs = 4;
  localparam int WordBits  = 16;

  // Redundant CPA product: CpaCoeffs chunks of CpaBits data bits plus one pending carry bit
  localparam int CpaBits   = 16;
  localparam int CpaCoeffs = 2 * NumCoeffs * WordBits / CpaBits;

  typedef logic [CpaCoeffs-1:0][CpaBits:0] cpa_poly_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROP = 2'd1,
    DONE = 2'd2
  } norm_state_e;

endpackage

// File: rtl/carry_chunk_add.sv
// One link of the carry-propagation chain: adds an incoming 2-bit carry to a redundant chunk.
// Latency: purely combinational.
// Backpressure: none; the caller owns all sequencing.
module carry_chunk_add
  import mrt_pkg::*;
(
  input  logic [CpaBits:0]   i_chunk,
  input  logic [1:0]         i_cin,
  output logic [CpaBits-1:0] o_sum,
  output logic [1:0]         o_cout
);

  // Two extra bits are needed: a full chunk (2^(CpaBits+1)-1) plus carry 1 overflows by 2.
  logic [CpaBits+1:0] w_s;

  // Widen both operands to CpaBits+2 and add
  always_comb begin
    w_s = {1'b0, i_chunk} + {{CpaBits{1'b0}}, i_cin};
  end

  assign o_sum  = w_s[CpaBits-1:0];
  assign o_cout = w_s[CpaBits+1:CpaBits];

endmodule

// File: rtl/poly_carry_norm.sv
// Normalizes the multiplier's redundant CPA product into a canonical binary integer plus carry-out.
// Latency: Beats cycles from accept to out_valid_o; one result every Beats+1 cycles.
// Backpressure: result held in DONE until out_ready_i; in_ready_o low while busy or clearing.
module poly_carry_norm
  import mrt_pkg::*;
#(
  parameter int ChunksPerCycle = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  cpa_poly_t                    cpa_product_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [CpaCoeffs*CpaBits-1:0] norm_o,
  output logic [1:0]                   carry_o
);

  localparam int Beats = CpaCoeffs / ChunksPerCycle;
  localparam int BeatW = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int IdxW  = (CpaCoeffs > 1) ? $clog2(CpaCoeffs) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);

  // A beat must cover a whole number of chunks, otherwise the tail would never be normalized.
  if ((CpaCoeffs % ChunksPerCycle) != 0) begin : g_bad_cfg
    $error("poly_carry_norm: ChunksPerCycle must divide CpaCoeffs");
  end

  norm_state_e r_state;
  norm_state_e w_state_nxt;
  cpa_poly_t   r_work;
  cpa_poly_t   w_work_nxt;
  logic [1:0]  r_carry;
  logic [BeatW-1:0] r_beat;
  logic        w_accept;
  logic        w_last_beat;
  logic [1:0]  w_cout_last;

  logic [ChunksPerCycle-1:0][CpaBits:0]   w_chunk;
  logic [ChunksPerCycle-1:0][CpaBits-1:0] w_sum;

  assign w_accept    = in_valid_i & in_ready_o;
  assign w_last_beat = (r_beat == LastBeat);

  // Pick out this beat's slice of the working register
  always_comb begin
    w_chunk = '0;
    for (int c = 0; c < ChunksPerCycle; c++) begin
      w_chunk[c] = r_work[IdxW'(int'(r_beat) * ChunksPerCycle + c)];
    end
  end

  // Ripple chain in ascending chunk order; stage 0 takes the carry left by the previous beat
  for (genvar g = 0; g < ChunksPerCycle; g++) begin : g_chain
    logic [1:0] w_ci;
    logic [1:0] w_co;

    if (g == 0) begin : g_first
      assign w_ci = r_carry;
    end else begin : g_next
      assign w_ci = g_chain[g-1].w_co;
    end

    carry_chunk_add u_add (
      .i_chunk (w_chunk[g]),
      .i_cin   (w_ci),
      .o_sum   (w_sum[g]),
      .o_cout  (w_co)
    );
  end

  assign w_cout_last = g_chain[ChunksPerCycle-1].w_co;

  // Write the normalized chunks back in place; their carry bits are now consumed
  always_comb begin
    w_work_nxt = r_work;
    for (int c = 0; c < ChunksPerCycle; c++) begin
      w_work_nxt[IdxW'(int'(r_beat) * ChunksPerCycle + c)] = {1'b0, w_sum[c]};
    end
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake outputs; clear_i overrides everything and blocks new input
  always_comb begin
    w_state_nxt = r_state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          w_state_nxt = PROP;
        end
      end
      PROP: begin
        if (w_last_beat) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid_o = 1'b1;
        // Consuming the result frees the register, so a new operand may land on the same edge
        in_ready_o  = out_ready_i;
        if (out_ready_i) begin
          w_state_nxt = in_valid_i ? PROP : IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (clear_i) begin
      w_state_nxt = IDLE;
      in_ready_o  = 1'b0;
    end
  end

  // Working register, running carry and beat counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_work  <= '0;
      r_carry <= 2'd0;
      r_beat  <= '0;
    end else if (clear_i) begin
      r_carry <= 2'd0;
      r_beat  <= '0;
    end else if (w_accept) begin
      r_work  <= cpa_product_i;
      r_carry <= 2'd0;
      r_beat  <= '0;
    end else if (r_state == PROP) begin
      r_work  <= w_work_nxt;
      // After the last beat this is the carry out of the top chunk and is held through DONE
      r_carry <= w_cout_last;
      r_beat  <= w_last_beat ? '0 : r_beat + 1'b1;
    end
  end

  // Flatten the data bits of the working register onto the result bus
  always_comb begin
    norm_o = '0;
    for (int i = 0; i < CpaCoeffs; i++) begin
      norm_o[i*CpaBits +: CpaBits] = r_work[i][CpaBits-1:0];
    end
  end

  assign carry_o = r_carry;

endmodule

// File: tb/tb_poly_carry_norm.sv
// Self-checking bench for poly_carry_norm with a 2-chunk-per-beat configuration.
// Expected results come from an integer reference model pushed to a scoreboard on accept.
// Results are popped and compared on each output handshake; latency checked on valid rise.
module tb_poly_carry_norm;
  import mrt_pkg::*;

  localparam int CPC   = 2;
  localparam int Beats = CpaCoeffs / CPC;
  localparam int NB    = CpaCoeffs * CpaBits;

  typedef struct {
    logic [NB-1:0] norm;
    logic [1:0]    carry;
    int            acc_edge;
  } exp_t;

  logic          clk_i;
  logic          rst_i;
  logic          clear_i;
  logic          in_valid_i;
  logic          in_ready_o;
  cpa_poly_t     cpa_product_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [NB-1:0] norm_o;
  logic [1:0]    carry_o;

  poly_carry_norm #(.ChunksPerCycle(CPC)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .clear_i       (clear_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .cpa_product_i (cpa_product_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .norm_o        (norm_o),
    .carry_o       (carry_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   edges  = 0;
  bit   prev_vld = 1'b0;
  bit   acc_flag = 1'b0;
  bit   cons_flag = 1'b0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer sum of the weighted chunks, split into low NB bits and carry-out
  function automatic exp_t model(input cpa_poly_t v, input int e);
    exp_t r;
    logic [255:0] s;
    s = '0;
    for (int i = 0; i < CpaCoeffs; i++) begin
      s = s + (256'(v[i]) << (i * CpaBits));
    end
    r.norm     = s[NB-1:0];
    r.carry    = s[NB+1:NB];
    r.acc_edge = e;
    return r;
  endfunction

  // Evaluate handshakes that will occur at the coming edge
  task automatic pre_edge();
    #1;
    acc_flag  = 1'b0;
    cons_flag = 1'b0;
    if (clear_i) begin
      sb.delete();
    end else begin
      if (out_valid_o && out_ready_i) begin
        cons_flag = 1'b1;
        check_eq("sb_nonempty", 256'(sb.size() > 0), 256'(1));
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check_eq("norm", norm_o, e.norm);
          check_eq("carry", carry_o, e.carry);
        end
      end
      if (in_valid_i && in_ready_o) begin
        acc_flag = 1'b1;
        sb.push_back(model(cpa_product_i, edges + 1));
      end
    end
  endtask

  task automatic monitor();
    if (out_valid_o && !prev_vld) begin
      if (sb.size() > 0) check_eq("latency", edges - sb[0].acc_edge, Beats);
      else               check_eq("spurious_vld", out_valid_o, 1'b0);
    end
    prev_vld = out_valid_o;
  endtask

  task automatic tick();
    pre_edge();
    @(posedge clk_i);
    edges++;
    #1;
    monitor();
  endtask

  task automatic send(input cpa_poly_t v);
    bit ok;
    ok = 1'b0;
    in_valid_i    = 1'b1;
    cpa_product_i = v;
    for (int k = 0; k < 50 && !ok; k++) begin
      tick();
      ok = acc_flag;
    end
    in_valid_i = 1'b0;
    check_eq("accepted", ok, 1'b1);
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && sb.size() > 0; k++) tick();
    check_eq("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    cpa_poly_t v;
    logic [NB-1:0] held;
    bit ok;

    rst_i = 1'b1; clear_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1; cpa_product_i = '0;
    #12;
    check_eq("rst_in_ready", in_ready_o, 1'b1);
    check_eq("rst_out_valid", out_valid_o, 1'b0);
    check_eq("rst_norm", norm_o, '0);
    check_eq("rst_carry", carry_o, 2'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Full ripple across every chunk
    for (int i = 0; i < CpaCoeffs; i++) v[i] = (i == 0) ? 17'h1_0000 : 17'h0_FFFF;
    send(v); drain();

    // Every chunk carries into the next
    for (int i = 0; i < CpaCoeffs; i++) v[i] = 17'h1_0000 | 17'(i);
    send(v); drain();

    // Maximum redundant input
    for (int i = 0; i < CpaCoeffs; i++) v[i] = 17'h1_FFFF;
    send(v); drain();

    // Backpressure, then consume and accept on the same edge
    for (int i = 0; i < CpaCoeffs; i++) v[i] = 17'(32'h1234 * (i + 3));
    out_ready_i = 1'b0;
    send(v);
    for (int k = 0; k < 20 && !out_valid_o; k++) tick();
    check_eq("bp_vld", out_valid_o, 1'b1);
    held = norm_o;
    for (int i = 0; i < CpaCoeffs; i++) v[i] = 17'(32'h1_F00F ^ (i * 32'h111));
    in_valid_i = 1'b1; cpa_product_i = v;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("bp_norm_stable", norm_o, held);
      check_eq("bp_in_ready", in_ready_o, 1'b0);
    end
    out_ready_i = 1'b1;
    tick();
    check_eq("b2b_consumed", cons_flag, 1'b1);
    check_eq("b2b_accepted", acc_flag, 1'b1);
    in_valid_i = 1'b0;
    drain();

    // Abort in the middle of propagation
    for (int i = 0; i < CpaCoeffs; i++) v[i] = 17'h1_8001;
    send(v);
    tick(); tick();
    clear_i = 1'b1; in_valid_i = 1'b1;
    #1;
    check_eq("clr_in_ready", in_ready_o, 1'b0);
    tick();
    clear_i = 1'b0; in_valid_i = 1'b0;
    #1;
    check_eq("clr_idle_ready", in_ready_o, 1'b1);
    for (int k = 0; k < 6; k++) begin
      tick();
      check_eq("clr_no_vld", out_valid_o, 1'b0);
    end
    for (int i = 0; i < CpaCoeffs; i++) v[i] = 17'(32'h0_ABCD + i);
    send(v); drain();

    // Asynchronous reset while propagating
    for (int i = 0; i < CpaCoeffs; i++) v[i] = 17'h1_7777;
    send(v);
    tick();
    #2 rst_i = 1'b1;
    #1;
    check_eq("arst_out_valid", out_valid_o, 1'b0);
    check_eq("arst_norm", norm_o, '0);
    check_eq("arst_carry", carry_o, 2'd0);
    check_eq("arst_in_ready", in_ready_o, 1'b1);
    sb.delete();
    prev_vld = 1'b0;
    #2 rst_i = 1'b0;
    for (int i = 0; i < CpaCoeffs; i++) v[i] = 17'h1_FFFE - 17'(i);
    send(v); drain();

    // Random operands under random consumer backpressure
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < CpaCoeffs; i++) v[i] = 17'($urandom);
      in_valid_i = 1'b1; cpa_product_i = v; ok = 1'b0;
      for (int k = 0; k < 100 && !ok; k++) begin
        out_ready_i = ($urandom_range(0, 3) != 0);
        tick();
        ok = acc_flag;
      end
      check_eq("rnd_accepted", ok, 1'b1);
      in_valid_i = 1'b0;
    end
    out_ready_i = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
